// File: rtl/seat_pkg.sv
// Shared types and widths for the seat request front end.
// Used by seat_cmd_fifo and seat_request_sequencer.
package seat_pkg;

    localparam int STUDENT_W = 32;
    localparam int SEAT_W    = 5;
    localparam int TIME_W    = 11;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        RELEASE = 2'b01,
        AWAY    = 2'b10,
        OCCUPY  = 2'b11
    } seat_state_t;

    typedef struct packed {
        logic [STUDENT_W-1:0] student_no;
        logic [SEAT_W-1:0]    seat_no;
        seat_state_t          state;
    } seat_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_GAP   = 2'b10
    } seq_state_t;

    // A request is usable only for a real seat (1..num_seats-1) and a non-EMPTY state.
    function automatic logic seat_req_ok(input logic [SEAT_W-1:0] seat,
                                         input logic [1:0] st,
                                         input int unsigned num_seats);
        return (seat != 5'd0) && (32'(seat) < num_seats) && (st != 2'b00);
    endfunction

endpackage

// File: rtl/seat_cmd_fifo.sv
// Synchronous FIFO of seat commands with full/empty flags and occupancy count.
// Head entry is presented combinationally on rdata.
module seat_cmd_fifo
    import seat_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  seat_cmd_t                wdata,
    output seat_cmd_t                rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    seat_cmd_t         mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              push_s;
    logic              pop_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == CW'(0));
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign rdata  = mem_r[rd_ptr_r];
    assign count  = count_r;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

endmodule

// File: rtl/seat_request_sequencer.sv
// Buffers seat requests and replays them as timed write commands; also generates minute-of-day Time.
// Optional build macro SEAT_RANGE_CHECK_EN drops bad seat/state requests and counts them in err_cnt.
module seat_request_sequencer
    import seat_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int TICKS_PER_MIN = 6000,
    parameter int MIN_PER_DAY   = 1440,
    parameter int HOLD_CYC      = 1,
    parameter int GAP_CYC       = 1,
    parameter int NUM_SEATS     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [STUDENT_W-1:0]     req_student_no,
    input  logic [SEAT_W-1:0]        req_seat_no,
    input  logic [1:0]               req_state,
    output logic                     write,
    output logic [STUDENT_W-1:0]     Student_No,
    output logic [SEAT_W-1:0]        Seat_No,
    output logic [1:0]               Seat_State,
    output logic [TIME_W-1:0]        Time,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               err_cnt
);

    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int MAXC   = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CNT_W  = $clog2(MAXC + 1);
    localparam int TICK_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;

    seq_state_t        state_r, state_nx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
    logic              pop_s, push_s, accept_s;
    logic              ready_r, nempty_r, write_r;
    logic              fifo_full_s, fifo_empty_s;
    logic [CW-1:0]     fifo_count_s, count_nx_s;
    seat_cmd_t         head_s, cmd_r, req_cmd_s;
    logic [TICK_W-1:0] tick_r;
    logic [TIME_W-1:0] time_r;

    assign accept_s  = req_valid && ready_r;
    assign req_cmd_s = '{student_no: req_student_no, seat_no: req_seat_no,
                         state: seat_state_t'(req_state)};

`ifdef SEAT_RANGE_CHECK_EN
    logic       req_ok_s;
    logic [7:0] err_cnt_r;

    assign req_ok_s = seat_req_ok(req_seat_no, req_state, NUM_SEATS);
    assign push_s   = accept_s && req_ok_s && !fifo_full_s;
    assign err_cnt  = err_cnt_r;

    // Saturating count of handshaken but discarded requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 8'h00;
        end else if (accept_s && !req_ok_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'h01;
        end
    end
`else
    assign push_s  = accept_s && !fifo_full_s;
    assign err_cnt = 8'h00;
`endif

    seat_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (req_cmd_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign count_nx_s = fifo_count_s + CW'(push_s) - CW'(pop_s);

    // Ready mirrors next-cycle fullness; nempty_r delays the FSM's view by one cycle for the N+2 latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r  <= 1'b1;
            nempty_r <= 1'b0;
        end else begin
            ready_r  <= (count_nx_s != CW'(DEPTH));
            nempty_r <= (fifo_count_s != CW'(0));
        end
    end

    // Next-state, pop and hold/gap counter.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        pop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (nempty_r && !fifo_empty_s) begin
                    state_nx_s = ST_ISSUE;
                    pop_s      = 1'b1;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cnt_r == CNT_W'(HOLD_CYC - 1)) begin
                    state_nx_s = ST_GAP;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s   = cnt_r + CNT_W'(1'b1);
                end
            end
            ST_GAP: begin
                if (cnt_r == CNT_W'(GAP_CYC - 1)) begin
                    cnt_nx_s = '0;
                    if (nempty_r && !fifo_empty_s) begin
                        state_nx_s = ST_ISSUE;
                        pop_s      = 1'b1;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1'b1);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // FSM state and registered command outputs; buses hold through GAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            write_r <= 1'b0;
            cmd_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            write_r <= (state_nx_s == ST_ISSUE);
            if (pop_s) begin
                cmd_r <= head_s;
            end
        end
    end

    // Free-running minute-of-day generator.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r <= '0;
            time_r <= '0;
        end else if (tick_r == TICK_W'(TICKS_PER_MIN - 1)) begin
            tick_r <= '0;
            time_r <= (time_r == TIME_W'(MIN_PER_DAY - 1)) ? TIME_W'(0) : time_r + TIME_W'(1'b1);
        end else begin
            tick_r <= tick_r + TICK_W'(1'b1);
        end
    end

    assign req_ready  = ready_r;
    assign write      = write_r;
    assign Student_No = cmd_r.student_no;
    assign Seat_No    = cmd_r.seat_no;
    assign Seat_State = cmd_r.state;
    assign Time       = time_r;
    assign fifo_count = fifo_count_s;

endmodule

// File: tb/tb_seat_request_sequencer.sv
// Self-checking bench for seat_request_sequencer: scoreboard of expected commands,
// one task per scenario. Expectations for the range test follow SEAT_RANGE_CHECK_EN.
module tb_seat_request_sequencer;

    localparam int DEPTH    = 8;
    localparam int TPM      = 4;
    localparam int MPD      = 1440;
    localparam int HOLD     = 2;
    localparam int GAP      = 3;
    localparam int NSEATS   = 31;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_student_no = 32'h0;
    logic [4:0]  req_seat_no = 5'd0;
    logic [1:0]  req_state = 2'b00;
    logic        write;
    logic [31:0] Student_No;
    logic [4:0]  Seat_No;
    logic [1:0]  Seat_State;
    logic [10:0] Time;
    logic [3:0]  fifo_count;
    logic [7:0]  err_cnt;

    int n_pass  = 0;
    int n_total = 0;
    logic [38:0] exp_q[$];

    always #5 clk = ~clk;

    seat_request_sequencer #(
        .DEPTH(DEPTH), .TICKS_PER_MIN(TPM), .MIN_PER_DAY(MPD),
        .HOLD_CYC(HOLD), .GAP_CYC(GAP), .NUM_SEATS(NSEATS)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_student_no(req_student_no), .req_seat_no(req_seat_no), .req_state(req_state),
        .write(write), .Student_No(Student_No), .Seat_No(Seat_No), .Seat_State(Seat_State),
        .Time(Time), .fifo_count(fifo_count), .err_cnt(err_cnt)
    );

    task automatic drive_req(input logic [31:0] s, input logic [4:0] seat, input logic [1:0] st);
        req_valid      = 1'b1;
        req_student_no = s;
        req_seat_no    = seat;
        req_state      = st;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_req(32'hDEAD_BEEF, 5'd3, 2'b11);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++; if (write !== 1'b0) $display("FAIL reset_write got %0b want 0", write); else n_pass++;
            n_total++; if (Time !== 11'd0) $display("FAIL reset_time got %0d want 0", Time); else n_pass++;
            n_total++; if (fifo_count !== 4'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else n_pass++;
        end
        rst = 1'b0;
        req_valid = 1'b0;
        n_total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", req_ready); else n_pass++;
        n_total++; if (Student_No !== 32'h0) $display("FAIL reset_student got %h want 0", Student_No); else n_pass++;
        n_total++; if (err_cnt !== 8'h0) $display("FAIL reset_err got %0d want 0", err_cnt); else n_pass++;
        @(negedge clk);
        n_total++; if (fifo_count !== 4'd0) $display("FAIL reset_nothing_accepted got %0d want 0", fifo_count); else n_pass++;
    endtask

    task automatic test_single();
        logic [38:0] e;
        n_total++; if (req_ready !== 1'b1) $display("FAIL single_ready got %0b want 1", req_ready); else n_pass++;
        drive_req(32'h01FF_FFFF, 5'd1, 2'b11);
        exp_q.push_back({32'h01FF_FFFF, 5'd1, 2'b11});
        @(negedge clk);
        req_valid = 1'b0;
        n_total++; if (write !== 1'b0) $display("FAIL single_lat_n got %0b want 0", write); else n_pass++;
        @(negedge clk);
        n_total++; if (write !== 1'b0) $display("FAIL single_lat_n1 got %0b want 0", write); else n_pass++;
        e = exp_q.pop_front();
        for (int h = 0; h < HOLD; h++) begin
            @(negedge clk);
            n_total++; if (write !== 1'b1) $display("FAIL single_write_hold%0d got %0b want 1", h, write); else n_pass++;
            n_total++;
            if ({Student_No, Seat_No, Seat_State} !== e)
                $display("FAIL single_bus got %h want %h", {Student_No, Seat_No, Seat_State}, e);
            else n_pass++;
        end
        @(negedge clk);
        n_total++; if (write !== 1'b0) $display("FAIL single_write_end got %0b want 0", write); else n_pass++;
        n_total++; if (Student_No !== 32'h01FF_FFFF) $display("FAIL single_gap_hold got %h want 01ffffff", Student_No); else n_pass++;
        repeat (GAP + 2) @(negedge clk);
    endtask

    task automatic test_burst();
        int sent = 0, high_run = 0, low_run = 99, cyc = 0, writes = 0;
        logic prev_w = 1'b0;
        logic saw_full = 1'b0;
        logic [38:0] e, d;
        while (cyc < 400 && (sent < 10 || exp_q.size() > 0 || write)) begin
            @(negedge clk);
            cyc++;
            if (write) begin
                if (!prev_w) begin
                    writes++;
                    n_total++; if (low_run < GAP) $display("FAIL burst_gap got %0d want >=%0d", low_run, GAP); else n_pass++;
                    n_total++;
                    if (exp_q.size() == 0) $display("FAIL burst_unexpected_write got %h want none", {Student_No, Seat_No, Seat_State});
                    else begin
                        e = exp_q.pop_front();
                        if ({Student_No, Seat_No, Seat_State} !== e)
                            $display("FAIL burst_order got %h want %h", {Student_No, Seat_No, Seat_State}, e);
                        else n_pass++;
                    end
                    high_run = 1;
                end else high_run++;
                low_run = 0;
            end else begin
                if (prev_w) begin
                    n_total++; if (high_run != HOLD) $display("FAIL burst_hold got %0d want %0d", high_run, HOLD); else n_pass++;
                end
                low_run++;
            end
            prev_w = write;
            if (fifo_count == 4'd8) saw_full = 1'b1;
            n_total++;
            if (req_ready !== (fifo_count != 4'd8))
                $display("FAIL burst_ready got %0b want %0b (count %0d)", req_ready, (fifo_count != 4'd8), fifo_count);
            else n_pass++;
            if (sent < 10 && req_ready) begin
                d = {32'h1000_0000 + 32'(sent), 5'(sent + 1), 2'(sent % 3 + 1)};
                drive_req(d[38:7], d[6:2], d[1:0]);
                exp_q.push_back(d);
                sent++;
            end else req_valid = 1'b0;
        end
        req_valid = 1'b0;
        n_total++; if (cyc >= 400) $display("FAIL burst_timeout got %0d cycles want <400", cyc); else n_pass++;
        n_total++; if (saw_full !== 1'b1) $display("FAIL burst_full got %0b want 1", saw_full); else n_pass++;
        n_total++; if (writes != 10) $display("FAIL burst_count got %0d want 10", writes); else n_pass++;
        exp_q.delete();
        repeat (GAP + 2) @(negedge clk);
    endtask

    task automatic test_time();
        int ev;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= TPM * MPD + 2 * TPM; k++) begin
            @(negedge clk);
            ev = (k / TPM) % MPD;
            n_total++;
            if (Time !== 11'(ev)) $display("FAIL time_k%0d got %0d want %0d", k, Time, ev);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        logic found = 1'b0, seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_req(32'hA000_0000 + 32'(i), 5'(i + 2), 2'b10);
        end
        while (cyc < 20 && !found) begin
            @(negedge clk);
            req_valid = 1'b0;
            cyc++;
            if (write && fifo_count == 4'd3) found = 1'b1;
        end
        n_total++; if (!found) $display("FAIL midrst_setup got count %0d want 3 during write", fifo_count); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++; if (write !== 1'b0) $display("FAIL midrst_write got %0b want 0", write); else n_pass++;
        n_total++; if (fifo_count !== 4'd0) $display("FAIL midrst_count got %0d want 0", fifo_count); else n_pass++;
        repeat (30) begin
            @(negedge clk);
            if (write) seen = 1'b1;
        end
        n_total++; if (seen) $display("FAIL midrst_stale got write=1 want none"); else n_pass++;
    endtask

    task automatic test_range();
        int writes = 0, exp_writes, exp_err;
        logic prev_w = 1'b0;
        logic [38:0] e;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`ifdef SEAT_RANGE_CHECK_EN
        exp_writes = 1; exp_err = 2;
        exp_q.push_back({32'h0000_0333, 5'd5, 2'b01});
`else
        exp_writes = 3; exp_err = 0;
        exp_q.push_back({32'h0000_0111, 5'd0, 2'b11});
        exp_q.push_back({32'h0000_0222, 5'd31, 2'b11});
        exp_q.push_back({32'h0000_0333, 5'd5, 2'b01});
`endif
        drive_req(32'h0000_0111, 5'd0, 2'b11);
        @(negedge clk);
        drive_req(32'h0000_0222, 5'd31, 2'b11);
        @(negedge clk);
        drive_req(32'h0000_0333, 5'd5, 2'b01);
        repeat (60) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (write && !prev_w) begin
                writes++;
                n_total++;
                if (exp_q.size() == 0) $display("FAIL range_unexpected got seat %0d want none", Seat_No);
                else begin
                    e = exp_q.pop_front();
                    if ({Student_No, Seat_No, Seat_State} !== e)
                        $display("FAIL range_cmd got %h want %h", {Student_No, Seat_No, Seat_State}, e);
                    else n_pass++;
                end
            end
            prev_w = write;
        end
        n_total++; if (writes != exp_writes) $display("FAIL range_writes got %0d want %0d", writes, exp_writes); else n_pass++;
        n_total++; if (err_cnt !== 8'(exp_err)) $display("FAIL range_err got %0d want %0d", err_cnt, exp_err); else n_pass++;
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_time();
        test_reset_mid();
        test_range();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
